// File: rtl/dcache_perf_monitor.sv
// dcache_perf_monitor
// Watches the dcache CPU-side port and controller status. It counts read/write
// hits and misses, write-backs and stall cycles, and captures the address of
// the last miss. Results are read through a registered select port.
// Optional feature macro: DCACHE_MON_LAT_EN adds per-miss latency tracking.
// When the macro is defined, select 6 returns the worst miss latency seen.
// When it is not defined, select 6 reads 0.
module dcache_perf_monitor #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_stall_i,
  input  logic              ctrl_idle_i,
  input  logic              sram_dirty_i,
  input  logic [2:0]        rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              sat_o
);

  // Counter slots; the index doubles as the readout select value.
  localparam int N_CNT   = 6;
  localparam int IDX_RH  = 0;
  localparam int IDX_RM  = 1;
  localparam int IDX_WH  = 2;
  localparam int IDX_WM  = 3;
  localparam int IDX_WB  = 4;
  localparam int IDX_STL = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              req;
  logic              is_wr;
  logic              miss_ev;
  logic              hit_ev;
  logic [N_CNT-1:0]  inc;
  logic [CNT_W-1:0]  cnt_q [N_CNT];
  logic [CNT_W-1:0]  cnt_d [N_CNT];
  logic              miss_pend_q, miss_pend_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  max_lat_val;
  logic [CNT_W-1:0]  addr_ext;

  // Classify this cycle's access; a simultaneous read+write counts as a write.
  always_comb begin
    req          = p1_MemRead_i | p1_MemWrite_i;
    is_wr        = p1_MemWrite_i;
    miss_ev      = req & p1_stall_i & ctrl_idle_i & ~miss_pend_q;
    hit_ev       = req & ~p1_stall_i & ~miss_pend_q;
    inc          = '0;
    inc[IDX_RH]  = hit_ev & ~is_wr;
    inc[IDX_RM]  = miss_ev & ~is_wr;
    inc[IDX_WH]  = hit_ev & is_wr;
    inc[IDX_WM]  = miss_ev & is_wr;
    inc[IDX_WB]  = miss_ev & sram_dirty_i;
    inc[IDX_STL] = p1_stall_i;
  end

  // Track the outstanding miss. This ignores enable so re-enabling mid-miss
  // cannot turn the completion cycle into a hit.
  always_comb begin
    miss_pend_d = miss_pend_q;
    if (clr_i)
      miss_pend_d = 1'b0;
    else if (miss_ev)
      miss_pend_d = 1'b1;
    else if (!p1_stall_i)
      miss_pend_d = 1'b0;
  end

  // Saturating event counters, captured miss address and sticky saturation flag.
  always_comb begin
    last_addr_d = last_addr_q;
    sat_d       = sat_q;
    for (int i = 0; i < N_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i)
        cnt_d[i] = '0;
      else if (enable_i && inc[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
    if (clr_i) begin
      last_addr_d = '0;
      sat_d       = 1'b0;
    end else begin
      if (enable_i && miss_ev)
        last_addr_d = p1_addr_i;
      for (int i = 0; i < N_CNT; i++)
        if (cnt_d[i] == CNT_MAX)
          sat_d = 1'b1;
    end
  end

`ifdef DCACHE_MON_LAT_EN
  logic [CNT_W-1:0] cur_lat_q, cur_lat_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;

  // Measure the running miss latency and keep the worst one seen at completion.
  always_comb begin
    cur_lat_d = cur_lat_q;
    max_lat_d = max_lat_q;
    if (clr_i) begin
      cur_lat_d = '0;
      max_lat_d = '0;
    end else if (enable_i) begin
      if (miss_ev)
        cur_lat_d = CNT_W'(1);
      else if (miss_pend_q && p1_stall_i && (cur_lat_q != CNT_MAX))
        cur_lat_d = cur_lat_q + 1'b1;
      if (miss_pend_q && !p1_stall_i && (cur_lat_q > max_lat_q))
        max_lat_d = cur_lat_q;
    end
  end

  // Latency state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_lat_q <= '0;
      max_lat_q <= '0;
    end else begin
      cur_lat_q <= cur_lat_d;
      max_lat_q <= max_lat_d;
    end
  end

  assign max_lat_val = max_lat_q;
`else
  assign max_lat_val = '0;
`endif

  // Fit the captured address to the readout width.
  if (ADDR_W >= CNT_W) begin : g_addr_trunc
    assign addr_ext = last_addr_q[CNT_W-1:0];
  end else begin : g_addr_zext
    assign addr_ext = {{(CNT_W-ADDR_W){1'b0}}, last_addr_q};
  end

  // Readout mux; it is registered, so it shows pre-edge register values.
  always_comb begin
    rd_data_d = '0;
    case (rd_sel_i)
      3'd0:    rd_data_d = cnt_q[IDX_RH];
      3'd1:    rd_data_d = cnt_q[IDX_RM];
      3'd2:    rd_data_d = cnt_q[IDX_WH];
      3'd3:    rd_data_d = cnt_q[IDX_WM];
      3'd4:    rd_data_d = cnt_q[IDX_WB];
      3'd5:    rd_data_d = cnt_q[IDX_STL];
      3'd6:    rd_data_d = max_lat_val;
      3'd7:    rd_data_d = addr_ext;
      default: rd_data_d = '0;
    endcase
  end

  // State registers with immediate reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CNT; i++)
        cnt_q[i] <= '0;
      miss_pend_q <= 1'b0;
      last_addr_q <= '0;
      sat_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++)
        cnt_q[i] <= cnt_d[i];
      miss_pend_q <= miss_pend_d;
      last_addr_q <= last_addr_d;
      sat_q       <= sat_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Bench for dcache_perf_monitor: a 32-bit instance and an 8-bit instance share stimulus.
// Readout requests push expected values into a queue.
// A monitor pops the queue and compares when the registered readout appears.
module tb_dcache_perf_monitor;

  typedef struct {
    string       nm;
    logic [2:0]  sel;
    logic [31:0] e32;
    logic [7:0]  e8;
    logic        s8;
  } exp_t;

`ifdef DCACHE_MON_LAT_EN
  localparam logic [31:0] LAT_EXP = 32'd10;
`else
  localparam logic [31:0] LAT_EXP = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        mrd;
  logic        mwr;
  logic [31:0] addr;
  logic        stall;
  logic        cidle;
  logic        dirty;
  logic [2:0]  rd_sel;
  logic [31:0] rd32;
  logic        sat32;
  logic [7:0]  rd8;
  logic        sat8;

  logic        rd_vld_in;
  logic        rd_vld_q;
  exp_t        sb[$];
  int          checks;
  int          errors;

  dcache_perf_monitor #(.CNT_W(32), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clr_i(clr),
    .p1_MemRead_i(mrd), .p1_MemWrite_i(mwr), .p1_addr_i(addr),
    .p1_stall_i(stall), .ctrl_idle_i(cidle), .sram_dirty_i(dirty),
    .rd_sel_i(rd_sel), .rd_data_o(rd32), .sat_o(sat32)
  );

  dcache_perf_monitor #(.CNT_W(8), .ADDR_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clr_i(clr),
    .p1_MemRead_i(mrd), .p1_MemWrite_i(mwr), .p1_addr_i(addr[7:0]),
    .p1_stall_i(stall), .ctrl_idle_i(cidle), .sram_dirty_i(dirty),
    .rd_sel_i(rd_sel), .rd_data_o(rd8), .sat_o(sat8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  always @(posedge clk) rd_vld_q <= rd_vld_in;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s value 0x%0h", nm, act);
    end
  endtask

  // Monitor: one registered readout is presented per requested cycle.
  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got readout 0x%0h expected none", rd32);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_d32"}, 64'(rd32), 64'(e.e32));
        check({e.nm, "_d8"}, 64'(rd8), 64'(e.e8));
        check({e.nm, "_sat32"}, 64'(sat32), 64'd0);
        check({e.nm, "_sat8"}, 64'(sat8), 64'(e.s8));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    en = 1'b1; clr = 1'b0; mrd = 1'b0; mwr = 1'b0; addr = '0;
    stall = 1'b0; cidle = 1'b1; dirty = 1'b0;
    rd_sel = 3'd0; rd_vld_in = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, input logic [31:0] e32, input logic [7:0] e8,
                    input logic s8, input string nm);
    exp_t e;
    idle_in();
    rd_sel = s;
    rd_vld_in = 1'b1;
    e.nm = nm; e.sel = s; e.e32 = e32; e.e8 = e8; e.s8 = s8;
    sb.push_back(e);
    cyc();
    rd_vld_in = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    idle_in();
    rst = 1'b1;
    #1;
    check({nm, "_rst_d32"}, 64'(rd32), 64'd0);
    check({nm, "_rst_sat8"}, 64'(sat8), 64'd0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_vld_in = 1'b0;

    // Reset, then three separate read hits.
    do_reset("t1");
    for (int i = 0; i < 3; i++) begin
      idle_in(); mrd = 1'b1; cyc();
      idle_in(); cyc();
    end
    rd(3'd0, 32'd3, 8'd3, 1'b0, "t1_rhit");
    for (int s = 1; s < 8; s++) rd(3'(s), 32'd0, 8'd0, 1'b0, "t1_zero");

    // Dirty write miss at 0x400 with a 10-cycle stall, then a hit right after completion.
    do_reset("t2");
    mwr = 1'b1; addr = 32'h400; dirty = 1'b1; stall = 1'b1; cidle = 1'b1; cyc();
    cidle = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    stall = 1'b0; cyc();
    cyc();
    rd(3'd3, 32'd1, 8'd1, 1'b0, "t2_wmiss");
    rd(3'd4, 32'd1, 8'd1, 1'b0, "t2_wback");
    rd(3'd5, 32'd10, 8'd10, 1'b0, "t2_stall");
    rd(3'd2, 32'd1, 8'd1, 1'b0, "t2_whit");
    rd(3'd0, 32'd0, 8'd0, 1'b0, "t2_rhit");
    rd(3'd1, 32'd0, 8'd0, 1'b0, "t2_rmiss");
    rd(3'd7, 32'h400, 8'h00, 1'b0, "t2_addr");
    rd(3'd6, LAT_EXP, LAT_EXP[7:0], 1'b0, "t2_lat");

    // Read and write together count as a write hit.
    do_reset("t3");
    mrd = 1'b1; mwr = 1'b1; cyc();
    rd(3'd2, 32'd1, 8'd1, 1'b0, "t3_whit");
    rd(3'd0, 32'd0, 8'd0, 1'b0, "t3_rhit");

    // 260 read hits saturate the 8-bit instance; clear wins over a concurrent hit.
    do_reset("t4");
    mrd = 1'b1;
    for (int i = 0; i < 260; i++) cyc();
    rd(3'd0, 32'd260, 8'd255, 1'b1, "t4_rhit_sat");
    idle_in(); mrd = 1'b1; clr = 1'b1; cyc();
    for (int s = 0; s < 8; s++) rd(3'(s), 32'd0, 8'd0, 1'b0, "t4_clr");

    // Enable low on the miss cycle; no miss and no completion hit, next hit counts.
    do_reset("t5");
    mrd = 1'b1; addr = 32'h44; stall = 1'b1; cidle = 1'b1; en = 1'b0; cyc();
    en = 1'b1; cidle = 1'b0; cyc();
    cyc();
    stall = 1'b0; cyc();
    idle_in(); cyc();
    mrd = 1'b1; cyc();
    rd(3'd1, 32'd0, 8'd0, 1'b0, "t5_rmiss");
    rd(3'd0, 32'd1, 8'd1, 1'b0, "t5_rhit");
    rd(3'd5, 32'd2, 8'd2, 1'b0, "t5_stall");
    rd(3'd7, 32'd0, 8'd0, 1'b0, "t5_addr");

    // Asynchronous reset mid-stall, then a re-issued stalled idle read.
    do_reset("t6");
    mrd = 1'b1; addr = 32'h88; stall = 1'b1; cidle = 1'b1; rd_sel = 3'd5; cyc();
    cidle = 1'b0; cyc();
    cyc();
    check("t6_pre_rst_d32", 64'(rd32), 64'd2);
    check("t6_pre_rst_d8", 64'(rd8), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_d32", 64'(rd32), 64'd0);
    check("t6_async_d8", 64'(rd8), 64'd0);
    cidle = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cidle = 1'b0; cyc();
    stall = 1'b0; cyc();
    idle_in(); cyc();
    rd(3'd1, 32'd1, 8'd1, 1'b0, "t6_rmiss");
    rd(3'd0, 32'd0, 8'd0, 1'b0, "t6_rhit");
    rd(3'd5, 32'd2, 8'd2, 1'b0, "t6_stall");
    rd(3'd7, 32'h88, 8'h88, 1'b0, "t6_addr");

    idle_in();
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
